// File: rtl/iob_cpu_bus_arbiter.sv
// Two-manager IOb arbiter: merges the CPU instruction (m0) and data (m1) buses onto a single
// subordinate port. Requests pass combinationally; a small ID FIFO routes each read response
// back to the manager that issued it.
module iob_cpu_bus_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_OUTST = 2,
  parameter bit          RR_EN     = 1'b1
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                m0_iob_valid_i,
  input  logic [ADDR_W-1:0]   m0_iob_addr_i,
  input  logic [DATA_W-1:0]   m0_iob_wdata_i,
  input  logic [DATA_W/8-1:0] m0_iob_wstrb_i,
  output logic                m0_iob_ready_o,
  output logic                m0_iob_rvalid_o,
  output logic [DATA_W-1:0]   m0_iob_rdata_o,
  input  logic                m1_iob_valid_i,
  input  logic [ADDR_W-1:0]   m1_iob_addr_i,
  input  logic [DATA_W-1:0]   m1_iob_wdata_i,
  input  logic [DATA_W/8-1:0] m1_iob_wstrb_i,
  output logic                m1_iob_ready_o,
  output logic                m1_iob_rvalid_o,
  output logic [DATA_W-1:0]   m1_iob_rdata_o,
  output logic                s_iob_valid_o,
  output logic [ADDR_W-1:0]   s_iob_addr_o,
  output logic [DATA_W-1:0]   s_iob_wdata_o,
  output logic [DATA_W/8-1:0] s_iob_wstrb_o,
  input  logic                s_iob_ready_i,
  input  logic                s_iob_rvalid_i,
  input  logic [DATA_W-1:0]   s_iob_rdata_i,
  output logic                err_o
);

  localparam int unsigned PtrW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTST + 1);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e                state_q, state_d;
  logic                  gnt_q, gnt_d;
  logic                  last_gnt_q, last_gnt_d;
  logic [CntW-1:0]       cnt_q;
  logic [PtrW-1:0]       wptr_q, rptr_q;
  logic [MAX_OUTST-1:0]  fifo_q;
  logic                  err_q;

  logic full, elig0, elig1, sel, req, xfer, sel_rd, push, pop, stray, head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  // Full uses the registered count only, so a same-cycle pop never admits a new read.
  assign full  = (cnt_q == CntW'(MAX_OUTST));
  assign elig0 = m0_iob_valid_i & ((m0_iob_wstrb_i != '0) | ~full);
  assign elig1 = m1_iob_valid_i & ((m1_iob_wstrb_i != '0) | ~full);

  // Arbitration and hold FSM: pick a winner in idle, lock onto it until accepted.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    sel        = 1'b0;
    req        = 1'b0;
    unique case (state_q)
      StIdle: begin
        req = elig0 | elig1;
        if (elig0 && elig1) sel = RR_EN ? ~last_gnt_q : 1'b1;
        else                sel = elig1;
        if (req) begin
          if (s_iob_ready_i) begin
            last_gnt_d = sel;
          end else begin
            gnt_d   = sel;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        sel = gnt_q;
        req = gnt_q ? m1_iob_valid_i : m0_iob_valid_i;
        // A manager withdrawing its request abandons the transfer.
        if (!req) begin
          state_d = StIdle;
        end else if (s_iob_ready_i) begin
          last_gnt_d = gnt_q;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Request mux and response routing.
  always_comb begin
    s_iob_addr_o  = sel ? m1_iob_addr_i  : m0_iob_addr_i;
    s_iob_wdata_o = sel ? m1_iob_wdata_i : m0_iob_wdata_i;
    s_iob_wstrb_o = sel ? m1_iob_wstrb_i : m0_iob_wstrb_i;
    sel_rd        = (s_iob_wstrb_o == '0);
    xfer          = req & s_iob_ready_i;
    push          = xfer & sel_rd;
    pop           = s_iob_rvalid_i & (cnt_q != '0);
    stray         = s_iob_rvalid_i & (cnt_q == '0);
    head          = fifo_q[rptr_q];

    s_iob_valid_o   = req & arst_n_i;
    m0_iob_ready_o  = xfer & ~sel & arst_n_i;
    m1_iob_ready_o  = xfer & sel & arst_n_i;
    m0_iob_rvalid_o = pop & ~head & arst_n_i;
    m1_iob_rvalid_o = pop & head & arst_n_i;
    m0_iob_rdata_o  = s_iob_rdata_i;
    m1_iob_rdata_o  = s_iob_rdata_i;
    err_o           = err_q;
  end

  // Arbiter state; last_gnt resets to m1 so m0 wins the first contested cycle.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= StIdle;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      err_q      <= 1'b0;
    end else if (cke_i) begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      if (stray) err_q <= 1'b1;
    end
  end

  // Requester-ID FIFO for reads in flight.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      fifo_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (cke_i) begin
      if (push) begin
        fifo_q[wptr_q] <= sel;
        wptr_q         <= ptr_inc(wptr_q);
      end
      if (pop) rptr_q <= ptr_inc(rptr_q);
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push && pop) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule
